// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci-class sequence generator.
package fib_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ADD  = 2'd2
    } state_t;

    localparam int TERM_CNT_W = 16;
    localparam int DEF_SEED_A = 0;
    localparam int DEF_SEED_B = 1;

    function automatic int nbytes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/fib_seq_byte_ser.sv
// Serialises one WIDTH-bit term into bytes, LSB byte first, over valid/ready.
module fib_seq_byte_ser
    import fib_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_send,
    input  logic             i_ready,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_valid,
    output logic [7:0]       o_data,
    output logic             o_last,
    output logic             o_term_done
);

    localparam int NB   = nbytes(WIDTH);
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

    logic [IDXW-1:0]  r_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_shift;

    assign o_valid     = i_send;
    assign o_last      = i_send && (r_idx == LAST_IDX);
    assign w_xfer      = i_send && i_ready;
    assign o_term_done = w_xfer && o_last;
    assign w_shift     = i_term >> {r_idx, 3'b000};
    // Data is forced to zero outside SEND so the idle bus reads clean.
    assign o_data      = i_send ? w_shift[7:0] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clear || o_term_done) begin
            r_idx <= '0;
        end else if (w_xfer) begin
            r_idx <= r_idx + IDXW'(1);
        end
    end

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci-class term generator: A/B pair, adder, FSM, byte-serial output.
// Build option: define FIB_SEQ_OVF_HALT_EN to stop before emitting a wrapped term.
module fib_seq_gen
    import fib_seq_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] SEED_A = WIDTH'(DEF_SEED_A),
    parameter logic [WIDTH-1:0] SEED_B = WIDTH'(DEF_SEED_B)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_load,
    input  logic [WIDTH-1:0]      seed_a,
    input  logic [WIDTH-1:0]      seed_b,
    input  logic                  run,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic                  overflow,
    output logic [TERM_CNT_W-1:0] term_count,
    output logic                  busy
);

    state_t                r_state, w_state_nxt;
    logic [WIDTH-1:0]      r_a, r_b;
    logic                  r_ovf;
    logic [TERM_CNT_W-1:0] r_term_cnt;
    logic [WIDTH:0]        w_sum;
    logic                  w_term_done;
    logic                  w_halt_idle, w_halt_add;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

`ifdef FIB_SEQ_OVF_HALT_EN
    logic r_a_carry, r_b_carry;

    // Carry flags travel with their terms; A's flag marks a wrapped emit candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_carry <= 1'b0;
            r_b_carry <= 1'b0;
        end else if (seed_load) begin
            r_a_carry <= 1'b0;
            r_b_carry <= 1'b0;
        end else if (r_state == ST_ADD) begin
            r_a_carry <= r_b_carry;
            r_b_carry <= w_sum[WIDTH];
        end
    end

    assign w_halt_idle = r_a_carry;
    assign w_halt_add  = r_b_carry;
`else
    assign w_halt_idle = 1'b0;
    assign w_halt_add  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (seed_load) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (run && !w_halt_idle) w_state_nxt = ST_SEND;
                ST_SEND: if (w_term_done) w_state_nxt = ST_ADD;
                ST_ADD:  w_state_nxt = (run && !w_halt_add) ? ST_SEND : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_a        <= SEED_A;
            r_b        <= SEED_B;
            r_ovf      <= 1'b0;
            r_term_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (seed_load) begin
                r_a        <= seed_a;
                r_b        <= seed_b;
                r_ovf      <= 1'b0;
                r_term_cnt <= '0;
            end else begin
                if (w_term_done) r_term_cnt <= r_term_cnt + TERM_CNT_W'(1);
                if (r_state == ST_ADD) begin
                    r_a <= r_b;
                    r_b <= w_sum[WIDTH-1:0];
                    if (w_sum[WIDTH]) r_ovf <= 1'b1;
                end
            end
        end
    end

    fib_seq_byte_ser #(.WIDTH(WIDTH)) u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (seed_load),
        .i_send      (r_state == ST_SEND),
        .i_ready     (out_ready),
        .i_term      (r_a),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_last      (out_last),
        .o_term_done (w_term_done)
    );

    assign overflow   = r_ovf;
    assign term_count = r_term_cnt;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen (WIDTH=16): arithmetic reference model, random ready.
module tb_fib_seq_gen;

    localparam int W  = 16;
    localparam int NB = W / 8;

    logic         clk = 1'b0;
    logic         rst, seed_load, run, out_ready;
    logic [W-1:0] seed_a, seed_b;
    logic         out_valid, out_last, overflow, busy;
    logic [7:0]   out_data;
    logic [15:0]  term_count;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0, n_total = 0;
    int   busy_total = 0;
    bit   rand_ready = 1'b0;

    fib_seq_gen #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_a(seed_a), .seed_b(seed_b),
        .run(run), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .overflow(overflow), .term_count(term_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference: terms t[k+2] = t[k] + t[k+1] mod 2^W, carry flag per computed term.
    task automatic model_phase(input logic [W-1:0] sa, input logic [W-1:0] sb, input int n,
                               output int emitted, output bit ovf_end);
        logic [W-1:0] t[$];
        bit           c[$];
        logic [W:0]   s;
        bit           ovf_now;
        exp_t         e;
        t.push_back(sa); t.push_back(sb);
        c.push_back(1'b0); c.push_back(1'b0);
        for (int i = 2; i <= n + 1; i++) begin
            s = {1'b0, t[i-2]} + {1'b0, t[i-1]};
            t.push_back(s[W-1:0]);
            c.push_back(s[W]);
        end
        emitted = 0;
        for (int k = 0; k < n; k++) begin
`ifdef FIB_SEQ_OVF_HALT_EN
            if (c[k]) break;
`endif
            ovf_now = 1'b0;
            for (int j = 2; j <= k + 1; j++) ovf_now |= c[j];
            for (int b = 0; b < NB; b++) begin
                e.data = 8'(t[k] >> (8 * b));
                e.last = (b == NB - 1);
                e.ovf  = ovf_now;
                exp_q.push_back(e);
            end
            emitted++;
        end
        ovf_end = 1'b0;
        for (int j = 2; j <= emitted + 1; j++) ovf_end |= c[j];
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, " out_valid"},  32'(out_valid),  32'd0);
        check({pfx, " out_data"},   32'(out_data),   32'd0);
        check({pfx, " out_last"},   32'(out_last),   32'd0);
        check({pfx, " overflow"},   32'(overflow),   32'd0);
        check({pfx, " term_count"}, 32'(term_count), 32'd0);
        check({pfx, " busy"},       32'(busy),       32'd0);
    endtask

    task automatic pulse_seed(input logic [W-1:0] sa, input logic [W-1:0] sb);
        seed_a = sa; seed_b = sb; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic run_phase(input string nm, input bit do_seed, input logic [W-1:0] sa,
                             input logic [W-1:0] sb, input int n, input bit rr);
        int emitted, cyc, b0;
        bit ovf_end;
        rand_ready = rr;
        if (do_seed) pulse_seed(sa, sb);
        model_phase(sa, sb, n, emitted, ovf_end);
        b0 = busy_total;
        run = 1'b1;
        cyc = 0;
        // Drop run during the final wanted term's SEND; that term still completes.
        while (!(out_valid && term_count == 16'(emitted - 1)) && cyc < 4000) begin
            @(posedge clk); #1; cyc++;
        end
        run = 1'b0;
        if (cyc >= 4000) fail_now({nm, " last_term_wait"});
        cyc = 0;
        while ((busy || exp_q.size() != 0) && cyc < 4000) begin
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= 4000) fail_now({nm, " drain_wait"});
        check({nm, " term_count"}, 32'(term_count), 32'(emitted));
        check({nm, " overflow"},   32'(overflow),   32'(ovf_end));
        if (!rr) check({nm, " busy_cycles"}, 32'(busy_total - b0), 32'((NB + 1) * emitted));
`ifdef FIB_SEQ_OVF_HALT_EN
        if (emitted < n) begin
            run = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            check({nm, " halted_busy"}, 32'(busy), 32'd0);
            run = 1'b0;
        end
`endif
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted byte and checks stall stability.
    initial begin
        bit         prev_stall = 1'b0;
        bit         prev_abort = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (busy) busy_total++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !prev_abort)
                    check("stall_hold", 32'({out_valid, out_data}), 32'({1'b1, prev_data}));
                if (out_valid && out_ready && !seed_load) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_byte: got %0h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'({out_data, out_last, overflow}), 32'({e.data, e.last, e.ovf}));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_abort = seed_load;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   cyc;
        rst = 1'b1; seed_load = 1'b0; run = 1'b0; seed_a = '0; seed_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("after_reset");

        run_phase("fib",   1'b0, 16'd0, 16'd1, 6, 1'b0);
        run_phase("lucas", 1'b1, 16'd2, 16'd1, 6, 1'b1);
        for (int r = 0; r < 3; r++)
            run_phase("rand", 1'b1, 16'($urandom), 16'($urandom), int'($urandom_range(2, 7)), 1'b1);

        // seed_load after the first byte of a term
        rand_ready = 1'b0;
        pulse_seed(16'd2, 16'd1);
        e.data = 8'h02; e.last = 1'b0; e.ovf = 1'b0;
        exp_q.push_back(e);
        run = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 20) fail_now("abort_seed valid_wait");
        @(posedge clk); #1;
        seed_load = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        seed_load = 1'b0;
        check("abort_seed out_valid",  32'(out_valid),    32'd0);
        check("abort_seed term_count", 32'(term_count),   32'd0);
        check("abort_seed busy",       32'(busy),         32'd0);
        check("abort_seed queue",      32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // rst in the middle of a term
        exp_q.push_back(e);
        run = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        if (cyc >= 20) fail_now("abort_rst valid_wait");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        check("mid_rst queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0;

        // Defaults restored by rst: run past the 16-bit wrap (F24, F25)
        run_phase("fib_ovf", 1'b0, 16'd0, 16'd1, 26, 1'b1);
`ifdef FIB_SEQ_OVF_HALT_EN
        run_phase("restart", 1'b1, 16'd0, 16'd1, 3, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised Fibonacci-class sequence generator: holds a pair of WIDTH-bit terms, emits the current term as a little-endian byte stream over a valid/ready handshake, then advances the pair by one addition. It generalises the fixed-width single-sequence Fibonacci core to any multiple-of-8 width, loadable seeds (Fibonacci, Lucas, arbitrary), overflow detection, and a term counter. It sits behind the tile's 8-bit output pins, with the top level mapping out_data to uo_out and the control inputs to ui_in/uio_in.

## Interface
- WIDTH, 32: term width in bits; multiple of 8, ≥ 8. NBYTES = WIDTH/8.
- SEED_A, 0: reset value of term register A.
- SEED_B, 1: reset value of term register B.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_load  in  1  single-cycle strobe; loads seed_a/seed_b, aborts any term in flight.
- seed_a  in  WIDTH  seed for A (current term).
- seed_b  in  WIDTH  seed for B (next term).
- run  in  1  level; high = produce terms continuously.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_valid  out  1  out_data holds a valid byte.
- out_data  out  8  current byte, LSB byte first.
- out_last  out  1  high with the final byte (byte NBYTES-1) of a term.
- overflow  out  1  sticky; an addition carried out of WIDTH bits.
- term_count  out  16  number of terms fully transferred since reset/seed_load; wraps at 2^16.
- busy  out  1  state ≠ IDLE.

## Operation
- Registers: A (emitted term), B (next term), a_carry, b_carry, byte index, state.
- States: IDLE, SEND, ADD.
- IDLE: if run=1 and not halted -> SEND (byte index 0). Otherwise hold.
- SEND: out_valid=1, out_data = A[8*idx +: 8]. Byte transfers when out_valid & out_ready. Non-final transfer: idx+1. Final transfer (out_last): term_count+1, -> ADD. out_data/out_valid stable while out_ready=0.
- ADD: {b_carry_new, B} <= A + B (WIDTH+1-bit sum); A <= B; a_carry <= b_carry; b_carry <= carry out. Carry out sets overflow. Next: SEND if run=1 and not halted, else IDLE.
- run dropping mid-SEND does not abort; the current term completes.
- seed_load (any state, priority over all other transitions): A<=seed_a, B<=seed_b, carries, overflow, term_count, idx cleared; -> IDLE; out_valid low next cycle. Partial term is discarded and not counted.
- Arithmetic is modulo 2^WIDTH; term_count wraps 0xFFFF -> 0x0000.

## Timing
- Reset values: A=SEED_A, B=SEED_B, state IDLE, out_valid=0, out_data=0, out_last=0, overflow=0, term_count=0, busy=0.
- First byte: out_valid high the cycle after run is sampled high in IDLE.
- Throughput with out_ready=1: NBYTES+1 cycles per term (NBYTES SEND + 1 ADD).
- overflow asserts the cycle after the ADD that carried.
- seed_load while SEND: out_valid low the following cycle; no byte transfers in the seed_load cycle's successor.

## Configuration
- FIB_SEQ_OVF_HALT_EN defined: once a_carry=1 (A holds a wrapped term), the block does not leave IDLE; run is ignored until seed_load or rst. No wrapped term is ever emitted.
- Undefined: generation continues, emitting wrapped values; overflow stays sticky as the only indication.

## Structure
- fib_seq_pkg: state enum (IDLE/SEND/ADD), TERM_CNT_W=16, default seed constants, helper NBYTES function.
- One sub-module: fib_seq_byte_ser (byte index counter, byte mux, out_valid/out_last, handshake); the core holds A/B, adder, carries, FSM.

## Test plan
- WIDTH=16, defaults, run=1, out_ready=1 -> byte stream 00 00, 01 00, 01 00, 02 00, 03 00, 05 00; out_last on every second byte; term_count=6; 3 cycles per term.
- seed_a=2, seed_b=1 via seed_load (Lucas) -> terms 2,1,3,4,7,11.
- out_ready toggled 1,0,0,1 during SEND -> out_data held constant while stalled, no byte lost or duplicated.
- WIDTH=16, wrap build, run to F25 -> overflow rises after the ADD following F23's transfer; F24=0xB520 (bytes 20 B5), F25 emitted as 0x2511 (bytes 11 25).
- Same with FIB_SEQ_OVF_HALT_EN -> F24 is last term emitted, busy=0, run ignored; seed_load then restarts from 0,1 with overflow=0.
- seed_load asserted after first byte of a term, and rst asserted mid-SEND -> out_valid low next cycle, term_count unchanged (seed_load) / all outputs at reset values (rst).
